popcount_neuron_seq: RTL

//  Sequential ternary-neuron controller. It time-multiplexes one combinational 10-input

---
 rtl/popcount_pkg.sv | 15 +
 rtl/popcount10_core.sv | 22 ++
 rtl/popcount_neuron_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount neuron controller.
// Both the controller and the 10-input popcount core import this package.
package popcount_pkg;

  localparam int PC_IN_W  = 10;
  localparam int PC_OUT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/popcount10_core.sv
// Combinational 10-input popcount, exact or approximate (selected by APPROX at build time).
// The approximate variant uses an OR for each bit-pair LSB, so it never under-counts.
module popcount10_core
  import popcount_pkg::*;
#(
  parameter bit APPROX = 1'b0
) (
  input  logic [PC_IN_W-1:0]  input_a,
  output logic [PC_OUT_W-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < PC_IN_W; i += 2) begin
      if (APPROX)
        out = out + {2'b00, input_a[i] & input_a[i+1], input_a[i] | input_a[i+1]};
      else
        out = out + {2'b00, input_a[i] & input_a[i+1], input_a[i] ^ input_a[i+1]};
    end
  end

endmodule

// File: rtl/popcount_neuron_seq.sv
// Ternary neuron controller: one popcount core reused over N_CHUNKS chunks in a
// positive pass then a negative pass; result is (acc_pos - acc_neg) compared against thr.
//
// state | meaning
// IDLE  | ready for a new job
// POS   | accumulating x & wpos, one chunk per cycle
// NEG   | accumulating x & wneg, one chunk per cycle
// DONE  | result held until downstream accepts
module popcount_neuron_seq
  import popcount_pkg::*;
#(
  parameter int N_CHUNKS = 4,
  parameter int THR_W    = 8,
  parameter bit APPROX   = 1'b0,
  localparam int N_IN    = PC_IN_W * N_CHUNKS
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [N_IN-1:0]         i_in_x,
  input  logic [N_IN-1:0]         i_in_wpos,
  input  logic [N_IN-1:0]         i_in_wneg,
  input  logic signed [THR_W-1:0] i_in_thr,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_out_act,
  output logic signed [THR_W-1:0] o_out_sum
);

  localparam int ACC_W = $clog2(15 * N_CHUNKS + 1);
  localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [N_IN-1:0]           r_x;
  logic [N_IN-1:0]           r_wpos;
  logic [N_IN-1:0]           r_wneg;
  logic signed [THR_W-1:0]   r_thr;
  logic [ACC_W-1:0]          r_acc_pos;
  logic [ACC_W-1:0]          r_acc_neg;
  logic                      r_out_valid;
  logic                      r_out_act;
  logic signed [THR_W-1:0]   r_out_sum;

  logic [PC_IN_W-1:0]        w_chunk_x;
  logic [PC_IN_W-1:0]        w_chunk_w;
  logic [PC_IN_W-1:0]        w_core_in;
  logic [PC_OUT_W-1:0]       w_core_out;
  logic [ACC_W-1:0]          w_core_ext;
  logic [ACC_W-1:0]          w_acc_neg_fin;
  logic signed [THR_W-1:0]   w_sum;
  logic                      w_act;
  logic                      w_last;
  logic                      w_accept;

  assign w_chunk_x = r_x[PC_IN_W*r_idx +: PC_IN_W];
  assign w_chunk_w = (r_state == NEG) ? r_wneg[PC_IN_W*r_idx +: PC_IN_W]
                                      : r_wpos[PC_IN_W*r_idx +: PC_IN_W];
  assign w_core_in = w_chunk_x & w_chunk_w;

  popcount10_core #(.APPROX(APPROX)) u_core (
    .input_a (w_core_in),
    .out     (w_core_out)
  );

  assign w_core_ext    = ACC_W'(w_core_out);
  assign w_last        = (r_idx == IDX_W'(N_CHUNKS - 1));
  assign w_accept      = (r_state == IDLE) && i_in_valid;
  // Last NEG chunk is folded in combinationally so the result lands on entry to DONE.
  assign w_acc_neg_fin = r_acc_neg + w_core_ext;
  assign w_sum         = THR_W'(r_acc_pos) - THR_W'(w_acc_neg_fin);
  assign w_act         = (w_sum >= r_thr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept)    w_state_nxt = POS;
      POS:  if (w_last)      w_state_nxt = NEG;
      NEG:  if (w_last)      w_state_nxt = DONE;
      DONE: if (i_out_ready) w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_x         <= '0;
      r_wpos      <= '0;
      r_wneg      <= '0;
      r_thr       <= '0;
      r_acc_pos   <= '0;
      r_acc_neg   <= '0;
      r_out_valid <= 1'b0;
      r_out_act   <= 1'b0;
      r_out_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x       <= i_in_x;
            r_wpos    <= i_in_wpos;
            r_wneg    <= i_in_wneg;
            r_thr     <= i_in_thr;
            r_acc_pos <= '0;
            r_acc_neg <= '0;
            r_idx     <= '0;
          end
        end
        POS: begin
          r_acc_pos <= r_acc_pos + w_core_ext;
          r_idx     <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        NEG: begin
          r_acc_neg <= w_acc_neg_fin;
          r_idx     <= w_last ? '0 : r_idx + IDX_W'(1);
          if (w_last) begin
            r_out_sum   <= w_sum;
            r_out_act   <= w_act;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_act   = r_out_act;
  assign o_out_sum   = r_out_sum;

endmodule
